// File: rtl/uart_tx.sv
// uart_tx: serial transmitter with a one-entry holding buffer, optional
// parity and one or two stop bits. Bit timing comes from the rising edges
// of an externally generated baud level signal.
//
// Handshake: a byte is accepted on a rising clk_i edge where
// tx_valid_i && tx_ready_o. tx_ready_o depends only on the holding buffer
// being empty. While tx_ready_o is low, tx_valid_i and tx_data_i are ignored.
module uart_tx #(
  parameter int DATA_BITS  = 8,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  input  logic                 baud_clk_i,
  input  logic [DATA_BITS-1:0] tx_data_i,
  input  logic                 tx_valid_i,
  output logic                 tx_ready_o,
  output logic                 tx_o,
  output logic                 busy_o
);

  localparam int CW = 3;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_e;

  state_e               state_q, state_d;
  logic                 baud_q;
  logic                 armed_q;
  logic                 tick;
  logic                 full_q, full_d;
  logic [DATA_BITS-1:0] buf_q, buf_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 par_q, par_d;
  logic                 tx_q, tx_d;
  logic                 accept;
  logic                 load;

  // armed_q only goes high once baud_clk_i has been seen low, so a baud
  // level that is already high at reset release cannot fake a rising edge.
  assign tick   = baud_clk_i & ~baud_q & armed_q;
  assign accept = tx_valid_i & ~full_q;

  assign tx_ready_o = ~full_q;
  assign tx_o       = tx_q;
  assign busy_o     = (state_q != IDLE) | full_q;

  // Baud edge detector.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      baud_q  <= 1'b0;
      armed_q <= 1'b0;
    end else begin
      baud_q  <= baud_clk_i;
      if (!baud_clk_i) armed_q <= 1'b1;
    end
  end

  // Holding buffer next state: accept and load never coincide because
  // accept needs an empty buffer and load needs a full one.
  always_comb begin
    full_d = accept | (full_q & ~load);
    buf_d  = accept ? tx_data_i : buf_q;
  end

  // Holding buffer registers; reset discards any held byte.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      full_q <= 1'b0;
      buf_q  <= '0;
    end else begin
      full_q <= full_d;
      buf_q  <= buf_d;
    end
  end

  // Frame sequencer: next state, shifter, counters and the next line level.
  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    cnt_d   = cnt_q;
    par_d   = par_q;
    tx_d    = tx_q;
    load    = 1'b0;
    case (state_q)
      IDLE: begin
        tx_d = 1'b1;
        if (tick && full_q) load = 1'b1;
      end
      START: begin
        if (tick) begin
          state_d = DATA;
          tx_d    = shift_q[0];
          shift_d = shift_q >> 1;
          cnt_d   = '0;
        end
      end
      DATA: begin
        if (tick) begin
          if (cnt_q == CW'(DATA_BITS - 1)) begin
            cnt_d = '0;
            if (PARITY_EN != 0) begin
              state_d = PARITY;
              tx_d    = par_q;
            end else begin
              state_d = STOP;
              tx_d    = 1'b1;
            end
          end else begin
            tx_d    = shift_q[0];
            shift_d = shift_q >> 1;
            cnt_d   = cnt_q + 3'd1;
          end
        end
      end
      PARITY: begin
        if (tick) begin
          state_d = STOP;
          tx_d    = 1'b1;
          cnt_d   = '0;
        end
      end
      STOP: begin
        tx_d = 1'b1;
        if (tick) begin
          if (cnt_q == CW'(STOP_BITS - 1)) begin
            if (full_q) load = 1'b1;
            else        state_d = IDLE;
          end else begin
            cnt_d = cnt_q + 3'd1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        tx_d    = 1'b1;
      end
    endcase
    // Starting a frame: take the held byte and drive the start bit next.
    if (load) begin
      state_d = START;
      shift_d = buf_q;
      par_d   = (^buf_q) ^ (PARITY_ODD != 0);
      cnt_d   = '0;
      tx_d    = 1'b0;
    end
  end

  // Sequencer registers; the line level is a flop that resets high.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= IDLE;
      shift_q <= '0;
      cnt_q   <= '0;
      par_q   <= 1'b0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
      par_q   <= par_d;
      tx_q    <= tx_d;
    end
  end

endmodule
